kf8255_strobe_handshake: RTL
============================

KF8255_STROBE_HANDSHAKE -- requirements
Module: kf8255_strobe_handshake

Interface
REQ-001 clock  input  1  system clock; all registers update on the falling edge.
REQ-002 reset  input  1  reset, asynchronous, active-high.
REQ-003 group_mode  input  2  group mode register value; handshake is active only when value is 2'b01 (mode 1).
REQ-004 port_io  input  1  port direction from group control; 1 = input, 0 = output.
REQ-005 mode_update  input  1  one-clock pulse, asserted when the group mode or direction is rewritten.
REQ-006 inte_write  input  1  one-clock pulse; loads inte from inte_value.
REQ-007 inte_value  input  1  new interrupt-enable value.
REQ-008 read_port  input  1  one-clock pulse, CPU read of the port.
REQ-009 write_port  input  1  one-clock pulse, CPU write of the port.
REQ-010 cpu_data  input  8  CPU write data.
REQ-011 port_in  input  8  external port pins.
REQ-012 strobe_n  input  1  external STB#, asynchronous, active-low.
REQ-013 ack_n  input  1  external ACK#, asynchronous, active-low.
REQ-014 read_data  output  8  input latch contents.
REQ-015 port_out  output  8  output latch contents.
REQ-016 port_out_en  output  1  high when mode 1 is active and port_io = 0.
REQ-017 ibf  output  1  input buffer full.
REQ-018 obf_n  output  1  output buffer full, active-low.
REQ-019 intr  output  1  interrupt request.
REQ-020 inte  output  1  interrupt-enable flag.
REQ-021 overrun  output  1  sticky flag: strobe arrived while ibf = 1.

Function
REQ-022 strobe_n and ack_n each pass through a two-flop synchronizer followed by a third flop for edge detection; an edge first sampled at edge k takes effect at edge k+2.
REQ-023 FSM states: DISABLED, IN_EMPTY, IN_FULL, OUT_EMPTY, OUT_FULL, OUT_ACK.
REQ-024 When group_mode != 01, the state is DISABLED, all handshake inputs are ignored, and ibf = 0, obf_n = 1, intr = 0.
REQ-025 When group_mode becomes 01, or on mode_update with group_mode = 01, the state becomes IN_EMPTY if port_io = 1, otherwise OUT_EMPTY.
REQ-026 mode_update clears ibf, intr, inte and overrun, sets obf_n = 1, and zeroes both latches; it has priority over every other event in the same cycle.
REQ-027 IN_EMPTY, STB# falling: latch port_in into read_data, set ibf = 1, go to IN_FULL.
REQ-028 IN_FULL, STB# rising: set intr = 1 if inte = 1.
REQ-029 IN_FULL, STB# falling: leave the latch unchanged and set overrun = 1.
REQ-030 IN_FULL, read_port: clear ibf and intr, go to IN_EMPTY; read_data holds its value.
REQ-031 read_port and STB# falling in the same cycle: the read is processed first, then the new data is latched; result is ibf = 1, intr = 0, state IN_FULL, overrun unchanged.
REQ-032 OUT_EMPTY/OUT_FULL, write_port: load cpu_data into port_out, set obf_n = 0, clear intr, go to OUT_FULL.
REQ-033 OUT_FULL, ACK# falling: set obf_n = 1, go to OUT_ACK.
REQ-034 OUT_ACK, ACK# rising: set intr = 1 if inte = 1, go to OUT_EMPTY.
REQ-035 OUT_ACK, write_port: behave as REQ-032; the pending ACK# rising then raises no interrupt.
REQ-036 OUT_EMPTY, ACK# edges are ignored.
REQ-037 inte_write updates inte on the next edge; clearing inte also clears intr, and setting inte does not raise intr by itself.
REQ-038 Clearing overrun requires reset or mode_update.

Reset
REQ-039 On reset: state DISABLED, read_data = port_out = 8'h00, ibf = 0, obf_n = 1, intr = 0, inte = 0, overrun = 0, all synchronizer flops = 1.
REQ-040 Reset asserted mid-handshake aborts the handshake immediately, without waiting for a clock edge.

Verification
REQ-041 Input path: mode 01, port_io = 1, inte = 1, port_in = 8'hA5, STB# pulsed low -> ibf = 1 two edges after the fall, read_data = A5, intr = 1 after STB# rises; read_port -> ibf = 0, intr = 0.
REQ-042 Overrun: ibf = 1, second STB# with port_in = 8'h3C -> read_data stays A5, overrun = 1.
REQ-043 Output path: port_io = 0, inte = 1, write_port with 8'h5A -> port_out = 5A, obf_n = 0; ACK# low -> obf_n = 1; ACK# high -> intr = 1.
REQ-044 Write during ACK: write 8'h11 while in OUT_ACK -> obf_n = 0, no intr on ACK# rise, state OUT_FULL.
REQ-045 Simultaneous read_port and STB# fall with port_in = 8'h77 -> ibf = 1, read_data = 77, intr = 0.
REQ-046 Reset or mode_update in IN_FULL with intr = 1 -> all outputs return to the REQ-039 values.

Source files
------------

// File: rtl/kf8255_strobe_handshake.sv
// Mode-1 strobed handshake for one 8255 port group: STB#/IBF input path, OBF#/ACK# output path,
// interrupt request and enable, and a sticky overrun flag. All state updates on the falling clock edge.
module kf8255_strobe_handshake (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [1:0] i_group_mode,
   input  logic       i_port_io,
   input  logic       i_mode_update,
   input  logic       i_inte_write,
   input  logic       i_inte_value,
   input  logic       i_read_port,
   input  logic       i_write_port,
   input  logic [7:0] i_cpu_data,
   input  logic [7:0] i_port_in,
   input  logic       i_strobe_n,
   input  logic       i_ack_n,
   output logic [7:0] o_read_data,
   output logic [7:0] o_port_out,
   output logic       o_port_out_en,
   output logic       o_ibf,
   output logic       o_obf_n,
   output logic       o_intr,
   output logic       o_inte,
   output logic       o_overrun,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      ST_DISABLED  = 3'd0,
      ST_IN_EMPTY  = 3'd1,
      ST_IN_FULL   = 3'd2,
      ST_OUT_EMPTY = 3'd3,
      ST_OUT_FULL  = 3'd4,
      ST_OUT_ACK   = 3'd5
   } state_t;

   state_t     r_state;
   logic [2:0] r_stb_sync;
   logic [2:0] r_ack_sync;
   logic [7:0] r_read_data;
   logic [7:0] r_port_out;
   logic       r_ibf;
   logic       r_obf_n;
   logic       r_intr;
   logic       r_inte;
   logic       r_overrun;

   state_t     w_state_nx;
   logic [7:0] w_read_data_nx;
   logic [7:0] w_port_out_nx;
   logic       w_ibf_nx;
   logic       w_obf_n_nx;
   logic       w_intr_nx;
   logic       w_inte_nx;
   logic       w_overrun_nx;
   logic       w_mode1;
   logic       w_stb_fall;
   logic       w_stb_rise;
   logic       w_ack_fall;
   logic       w_ack_rise;

   assign w_mode1 = (i_group_mode == 2'b01);

   // Bit 1 is the synchronized level, bit 2 its previous value; edges act one edge after bit 1 settles.
   assign w_stb_fall = r_stb_sync[2] & ~r_stb_sync[1];
   assign w_stb_rise = ~r_stb_sync[2] & r_stb_sync[1];
   assign w_ack_fall = r_ack_sync[2] & ~r_ack_sync[1];
   assign w_ack_rise = ~r_ack_sync[2] & r_ack_sync[1];

   always_comb begin
      w_state_nx     = r_state;
      w_read_data_nx = r_read_data;
      w_port_out_nx  = r_port_out;
      w_ibf_nx       = r_ibf;
      w_obf_n_nx     = r_obf_n;
      w_intr_nx      = r_intr;
      w_inte_nx      = r_inte;
      w_overrun_nx   = r_overrun;
      if (i_mode_update) begin
         w_read_data_nx = 8'h00;
         w_port_out_nx  = 8'h00;
         w_ibf_nx       = 1'b0;
         w_obf_n_nx     = 1'b1;
         w_intr_nx      = 1'b0;
         w_inte_nx      = 1'b0;
         w_overrun_nx   = 1'b0;
         if (!w_mode1)
            w_state_nx = ST_DISABLED;
         else
            w_state_nx = i_port_io ? ST_IN_EMPTY : ST_OUT_EMPTY;
      end else begin
         if (!w_mode1) begin
            w_state_nx = ST_DISABLED;
            w_ibf_nx   = 1'b0;
            w_obf_n_nx = 1'b1;
            w_intr_nx  = 1'b0;
         end else begin
            case (r_state)
               ST_DISABLED: w_state_nx = i_port_io ? ST_IN_EMPTY : ST_OUT_EMPTY;
               ST_IN_EMPTY: begin
                  if (w_stb_fall) begin
                     w_read_data_nx = i_port_in;
                     w_ibf_nx       = 1'b1;
                     w_state_nx     = ST_IN_FULL;
                  end
               end
               ST_IN_FULL: begin
                  // A read in the same cycle as a new strobe frees the buffer first, so the strobe latches.
                  if (i_read_port) begin
                     w_ibf_nx   = 1'b0;
                     w_intr_nx  = 1'b0;
                     w_state_nx = ST_IN_EMPTY;
                     if (w_stb_fall) begin
                        w_read_data_nx = i_port_in;
                        w_ibf_nx       = 1'b1;
                        w_state_nx     = ST_IN_FULL;
                     end
                  end else if (w_stb_fall) begin
                     w_overrun_nx = 1'b1;
                  end else if (w_stb_rise && r_inte) begin
                     w_intr_nx = 1'b1;
                  end
               end
               ST_OUT_EMPTY, ST_OUT_FULL, ST_OUT_ACK: begin
                  if (i_write_port) begin
                     w_port_out_nx = i_cpu_data;
                     w_obf_n_nx    = 1'b0;
                     w_intr_nx     = 1'b0;
                     w_state_nx    = ST_OUT_FULL;
                  end else if (r_state == ST_OUT_FULL && w_ack_fall) begin
                     w_obf_n_nx = 1'b1;
                     w_state_nx = ST_OUT_ACK;
                  end else if (r_state == ST_OUT_ACK && w_ack_rise) begin
                     w_intr_nx  = r_inte;
                     w_state_nx = ST_OUT_EMPTY;
                  end
               end
               default: w_state_nx = ST_DISABLED;
            endcase
         end
         if (i_inte_write) begin
            w_inte_nx = i_inte_value;
            if (!i_inte_value)
               w_intr_nx = 1'b0;
         end
      end
   end

   always_ff @(negedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_DISABLED;
         r_stb_sync  <= 3'b111;
         r_ack_sync  <= 3'b111;
         r_read_data <= 8'h00;
         r_port_out  <= 8'h00;
         r_ibf       <= 1'b0;
         r_obf_n     <= 1'b1;
         r_intr      <= 1'b0;
         r_inte      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_stb_sync  <= {r_stb_sync[1:0], i_strobe_n};
         r_ack_sync  <= {r_ack_sync[1:0], i_ack_n};
         r_read_data <= w_read_data_nx;
         r_port_out  <= w_port_out_nx;
         r_ibf       <= w_ibf_nx;
         r_obf_n     <= w_obf_n_nx;
         r_intr      <= w_intr_nx;
         r_inte      <= w_inte_nx;
         r_overrun   <= w_overrun_nx;
      end
   end

   assign o_read_data   = r_read_data;
   assign o_port_out    = r_port_out;
   assign o_port_out_en = w_mode1 & ~i_port_io;
   assign o_ibf         = r_ibf;
   assign o_obf_n       = r_obf_n;
   assign o_intr        = r_intr;
   assign o_inte        = r_inte;
   assign o_overrun     = r_overrun;
   assign o_dbg_state   = r_state;

endmodule
